// File: rtl/filter_pkg.sv
// Shared definitions for the multichannel FIR filter: mode/state encodings,
// default parameters, accumulator sizing and the 31-tap coefficient tables.
package filter_pkg;

   localparam int DEF_DATA_W   = 16;
   localparam int DEF_COEF_W   = 10;
   localparam int DEF_TAPS     = 31;
   localparam int DEF_CHANNELS = 2;

   // Coefficient tables are scaled for unity gain = 512.
   localparam int TABLE_UNITY  = 512;
   localparam int TABLE_LEN    = 31;
   localparam int TABLE_CENTER = 15;

   typedef enum logic [1:0] {
      MODE_BYPASS   = 2'b00,
      MODE_LOWPASS  = 2'b01,
      MODE_HIGHPASS = 2'b10,
      MODE_BYPASS_B = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MAC  = 2'b01,
      ST_OUT  = 2'b10
   } state_e;

   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   // Symmetric lowpass, sum = 512; only the first half plus center is stored.
   function automatic int lp_coef(input int i);
      int j;
      if (i < 0 || i >= TABLE_LEN) return 0;
      j = (i > TABLE_CENTER) ? (TABLE_LEN - 1 - i) : i;
      case (j)
         0:  return -1;
         1:  return -2;
         2:  return -2;
         3:  return 0;
         4:  return 3;
         5:  return 5;
         6:  return 3;
         7:  return -3;
         8:  return -9;
         9:  return -10;
         10: return 0;
         11: return 20;
         12: return 44;
         13: return 66;
         14: return 80;
         15: return 124;
         default: return 0;
      endcase
   endfunction

   // Spectral inversion of the lowpass: delta minus lowpass, so the sum is 0.
   function automatic int hp_coef(input int i);
      if (i < 0 || i >= TABLE_LEN) return 0;
      return ((i == TABLE_CENTER) ? TABLE_UNITY : 0) - lp_coef(i);
   endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup by latched mode and tap index.
module fir_coef_rom
   import filter_pkg::*;
#(
   parameter int COEF_W = DEF_COEF_W,
   parameter int TAP_W  = 5
)(
   input  logic [1:0]        mode,
   input  logic [TAP_W-1:0]  tap,
   output logic signed [COEF_W:0] coef
);

   // One extra bit so the bypass unity coefficient (2^(COEF_W-1)) is representable.
   localparam logic signed [COEF_W:0] UNITY = (COEF_W+1)'(2 ** (COEF_W - 1));

   always_comb begin
      coef = '0;
      case (mode)
         MODE_LOWPASS:  coef = (COEF_W+1)'(lp_coef(int'(tap)));
         MODE_HIGHPASS: coef = (COEF_W+1)'(hp_coef(int'(tap)));
         default:       coef = (tap == '0) ? UNITY : '0;
      endcase
   end

endmodule

// File: rtl/fir_filter_control.sv
// Time-multiplexed FIR: one tap per cycle, all channels in parallel, with a
// shared IDLE/MAC/OUT sequencer and per-channel delay lines.
module fir_filter_control
   import filter_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int COEF_W   = DEF_COEF_W,
   parameter int TAPS     = DEF_TAPS,
   parameter int CHANNELS = DEF_CHANNELS
)(
   input  logic                         clock,
   input  logic                         reset,
   input  logic [1:0]                   mode,
   input  logic                         sample_valid,
   input  logic [CHANNELS*DATA_W-1:0]   sample_in,
   output logic                         ready,
   output logic [CHANNELS*DATA_W-1:0]   audio_out,
   output logic                         done
);

   localparam int TAP_W = $clog2(TAPS);
   localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
   localparam logic [TAP_W-1:0]        LAST_TAP = TAP_W'(TAPS - 1);
   localparam logic signed [ACC_W-1:0] RND      = ACC_W'(2 ** (COEF_W - 2));
   localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] ACC_MAX  = ACC_W'(OUT_MAX);
   localparam logic signed [ACC_W-1:0] ACC_MIN  = ACC_W'(OUT_MIN);

   state_e                  state, state_nxt;
   logic [TAP_W-1:0]        tap, wptr, rd_ptr;
   logic [1:0]              mode_q;
   logic signed [COEF_W:0]  coef;
   logic                    accept, mac_en, last_tap;

   always_ff @(posedge clock) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (sample_valid) state_nxt = ST_MAC;
         ST_MAC:  if (last_tap)     state_nxt = ST_OUT;
         ST_OUT:                    state_nxt = ST_IDLE;
         default:                   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      ready  = (state == ST_IDLE);
      done   = (state == ST_OUT);
      mac_en = (state == ST_MAC);
   end

   assign accept   = sample_valid && ready;
   assign last_tap = (tap == LAST_TAP);

   always_ff @(posedge clock) begin
      if (reset) begin
         tap    <= '0;
         wptr   <= '0;
         mode_q <= MODE_BYPASS;
      end else if (accept) begin
         tap    <= '0;
         mode_q <= mode;
      end else if (mac_en) begin
         if (last_tap) wptr <= (wptr == LAST_TAP) ? '0 : wptr + TAP_W'(1);
         else          tap  <= tap + TAP_W'(1);
      end
   end

   // (wptr - tap) mod TAPS; modular wrap of the pointer width keeps it exact.
   always_comb begin
      if (wptr >= tap) rd_ptr = wptr - tap;
      else             rd_ptr = wptr + TAP_W'(TAPS) - tap;
   end

   fir_coef_rom #(.COEF_W(COEF_W), .TAP_W(TAP_W)) u_rom (
      .mode (mode_q),
      .tap  (tap),
      .coef (coef)
   );

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [DATA_W-1:0] dly [TAPS];
      logic signed [DATA_W-1:0] x_new, x_tap, aud, sat;
      logic signed [ACC_W-1:0]  acc, acc_nxt, scaled;

      assign x_new   = sample_in[c*DATA_W +: DATA_W];
      assign x_tap   = dly[rd_ptr];
      assign acc_nxt = acc + ACC_W'(x_tap) * ACC_W'(coef);
      assign scaled  = (acc_nxt + RND) >>> (COEF_W - 1);

      // Result is taken from the final-tap sum so audio_out is valid with done.
      always_comb begin
         if (scaled > ACC_MAX)      sat = OUT_MAX;
         else if (scaled < ACC_MIN) sat = OUT_MIN;
         else                       sat = scaled[DATA_W-1:0];
      end

      always_ff @(posedge clock) begin
         if (reset) begin
            for (int i = 0; i < TAPS; i++) dly[i] <= '0;
            acc <= '0;
            aud <= '0;
         end else if (accept) begin
            dly[wptr] <= x_new;
            acc       <= '0;
         end else if (mac_en) begin
            acc <= acc_nxt;
            if (last_tap) aud <= sat;
         end
      end

      assign audio_out[c*DATA_W +: DATA_W] = aud;
   end

endmodule

// File: tb/tb_fir_filter_control.sv
// Randomized scoreboard bench for fir_filter_control against a sample-history
// convolution model.
module tb_fir_filter_control;

   localparam int DW   = 16;
   localparam int CW   = 10;
   localparam int TAPS = 31;
   localparam int CH   = 2;
   localparam int LP [31] = '{-1, -2, -2, 0, 3, 5, 3, -3, -9, -10, 0, 20, 44, 66, 80, 124,
                              80, 66, 44, 20, 0, -10, -9, -3, 3, 5, 3, 0, -2, -2, -1};

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        mode = 2'b00;
   logic              sample_valid = 1'b0;
   logic [CH*DW-1:0]  sample_in = '0;
   logic              ready, done;
   logic [CH*DW-1:0]  audio_out;

   fir_filter_control #(.DATA_W(DW), .COEF_W(CW), .TAPS(TAPS), .CHANNELS(CH)) dut (
      .clock        (clock),
      .reset        (reset),
      .mode         (mode),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .ready        (ready),
      .audio_out    (audio_out),
      .done         (done)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sbq [$];
   exp_t mon_e;
   int   hist0 [$];
   int   hist1 [$];
   int   free_cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;

   function automatic int coef(input int m, input int i);
      case (m)
         1:       return LP[i];
         2:       return ((i == 15) ? 512 : 0) - LP[i];
         default: return (i == 0) ? 512 : 0;
      endcase
   endfunction

   // y = sum h[i]*x[n-i], round half up, divide by 512 (floor), clamp to 16 bits
   function automatic int filt(input int m, input int ch);
      longint acc, q;
      int     x;
      acc = 0;
      for (int i = 0; i < TAPS; i++) begin
         if (ch == 0) x = (i < hist0.size()) ? hist0[i] : 0;
         else         x = (i < hist1.size()) ? hist1[i] : 0;
         acc += longint'(coef(m, i)) * longint'(x);
      end
      q = acc + 256;
      if (q >= 0) q = q / 512;
      else        q = -((-q + 511) / 512);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   function automatic int rnd16();
      logic signed [15:0] r;
      r = 16'($urandom());
      return int'(r);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && done) begin
         if (sbq.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_done at cycle %0d: got done=1, expected 0", cyc);
         end else begin
            mon_e = sbq.pop_front();
            check("out_ch0", $signed(audio_out[15:0]),  $signed(mon_e.data[15:0]));
            check("out_ch1", $signed(audio_out[31:16]), $signed(mon_e.data[31:16]));
            check("latency", cyc, mon_e.cyc);
         end
      end
   end

   task automatic model_accept(input int m, input int a, input int b);
      exp_t e;
      hist0.push_front(a);
      hist1.push_front(b);
      if (hist0.size() > TAPS) void'(hist0.pop_back());
      if (hist1.size() > TAPS) void'(hist1.pop_back());
      e.data = {16'(filt(m, 1)), 16'(filt(m, 0))};
      e.cyc  = cyc + TAPS + 1;
      sbq.push_back(e);
      free_cyc = cyc + TAPS + 2;
   endtask

   // Called just after a falling edge; returns at the next falling edge.
   task automatic drive(input bit v, input logic [1:0] m, input int a, input int b);
      sample_valid = v;
      mode         = m;
      sample_in    = {16'(b), 16'(a)};
      check("ready", longint'(ready), longint'(cyc >= free_cyc));
      if (v && cyc >= free_cyc) model_accept(int'(m), a, b);
      @(negedge clock);
   endtask

   task automatic send(input logic [1:0] m, input int a, input int b);
      while (cyc < free_cyc) drive(1'b0, 2'($urandom()), rnd16(), rnd16());
      drive(1'b1, m, a, b);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sbq.size() > 0 && t < 200) begin
         drive(1'b0, 2'($urandom()), 0, 0);
         t++;
      end
      check("drain_pending", sbq.size(), 0);
   endtask

   // Holds sample_valid high through reset to show reset wins.
   task automatic do_reset();
      reset        = 1'b1;
      sample_valid = 1'b1;
      mode         = 2'b01;
      sample_in    = 32'h7fff_7fff;
      sbq.delete();
      hist0.delete();
      hist1.delete();
      repeat (2) @(negedge clock);
      reset        = 1'b0;
      sample_valid = 1'b0;
      free_cyc     = cyc;
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_audio", audio_out, 0);
   endtask

   initial begin
      @(negedge clock);
      do_reset();

      // bypass, both encodings
      send(2'b00, 'h1234, -292);
      send(2'b11, rnd16(), rnd16());
      drain();

      // lowpass impulse on ch0
      do_reset();
      send(2'b01, 512, 0);
      repeat (31) send(2'b01, 0, 0);
      drain();

      // DC gain: lowpass full-scale, then highpass on a filled line
      do_reset();
      repeat (31) send(2'b01, 32767, -32768);
      repeat (5)  send(2'b10, 32767, -32768);
      // alternating full-scale through highpass drives saturation
      for (int i = 0; i < 40; i++) send(2'b10, (i % 2) ? -32768 : 32767, (i % 2) ? 32767 : -32768);
      for (int i = 0; i < 30; i++) send(2'($urandom()), rnd16(), rnd16());
      drain();

      // valid held high, mode toggling every cycle
      for (int i = 0; i < 200; i++) drive(1'b1, (i % 2) ? 2'b01 : 2'b10, rnd16(), rnd16());
      drain();

      // reset in MAC cycle 10, then a clean impulse
      send(2'b01, 512, 0);
      repeat (10) drive(1'b0, 2'b10, 0, 0);
      do_reset();
      repeat (3) drive(1'b0, 2'b00, 0, 0);
      send(2'b01, 512, 0);
      repeat (31) send(2'b01, 0, 0);
      drain();

      // ramp across the pointer wrap
      do_reset();
      for (int i = 0; i < 70; i++) send(2'b01, -3000 + 97 * i, 2500 - 113 * i);
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
